// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-type constants and the default payload width.
package uart_tx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Each state names the bit currently driven on the serial line.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shifter for uart_tx: holds the latched word, shifts it out LSB
// first and flags when every payload bit has been handed to the line.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  bit_out,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CW-1:0]         cnt_q;

  // cnt_q counts payload bits already driven onto the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      data_q  <= din;
      shreg_q <= din;
      cnt_q   <= '0;
    end else if (shift) begin
      shreg_q <= shreg_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign bit_out = shreg_q[0];
  assign done    = (cnt_q == CW'(DATA_WIDTH));
  assign data    = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from an upstream FIFO and sends start,
// LSB-first payload, optional parity and stop bits, one bit per clk.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  rinc,
  output logic                  tx_out,
  output logic                  busy
);

  state_t state_q, state_d;
  logic   tx_q, tx_d;
  logic   busy_q, busy_d;
  logic   rinc_q;
  logic   par_en_q, par_typ_q;
  logic   pop, shift;

  logic                  ser_bit;
  logic                  ser_done;
  logic [DATA_WIDTH-1:0] ser_data;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pop),
    .shift  (shift),
    .din    (rdata),
    .bit_out(ser_bit),
    .done   (ser_done),
    .data   (ser_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rinc_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rinc_q  <= pop;
      if (pop) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
    end
  end

  // tx_d is the line value for the state being entered, so tx_out is a
  // plain register yet always matches state_q.
  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    busy_d  = 1'b1;
    pop     = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!rempty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser_bit;
        shift   = 1'b1;
      end
      DATA: begin
        if (!ser_done) begin
          tx_d  = ser_bit;
          shift = 1'b1;
        end else if (par_en_q) begin
          state_d = PARITY;
          tx_d    = parity_bit(^ser_data, par_typ_q);
        end else begin
          state_d = STOP;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (!rempty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign rinc   = rinc_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes words into a FIFO model and
// expected frames into a queue; a line monitor decodes frames and compares.
module tb_uart_tx;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par_en;
    logic          par_bit;
  } exp_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          rempty  = 1'b1;
  logic [DW-1:0] rdata   = '0;
  logic          par_en  = 1'b0;
  logic          par_typ = 1'b0;
  logic          rinc;
  logic          tx_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rinc_cnt = 0;

  logic [DW-1:0] fifo[$];
  exp_t          exp_q[$];
  int            starts[$];

  uart_tx #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .par_en (par_en),
    .par_typ(par_typ),
    .rinc   (rinc),
    .tx_out (tx_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_update();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? '0 : fifo[0];
  endtask

  task automatic push(input logic [DW-1:0] d, input logic pe, input logic pb);
    fifo.push_back(d);
    exp_q.push_back(exp_t'{data: d, par_en: pe, par_bit: pb});
    fifo_update();
  endtask

  // FIFO read side: the pop pulse is consumed once per cycle.
  always @(negedge clk) begin
    if (rinc) begin
      check("rinc_nonempty", 32'(fifo.size() != 0), 1);
      if (fifo.size() != 0) void'(fifo.pop_front());
      fifo_update();
      rinc_cnt++;
    end
  end

  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] d;
    bit            ab;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (tx_out == 1'b1) begin
        check("idle_ctl", {30'd0, busy, rinc}, 0);
        continue;
      end
      starts.push_back(cyc);
      check("start_ctl", {30'd0, busy, rinc}, 3);
      check("frame_expected", 32'(exp_q.size() != 0), 1);
      e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      d  = '0;
      ab = 1'b0;
      for (int i = 0; i < DW; i++) begin
        @(negedge clk);
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        d[i] = tx_out;
        check("data_ctl", {30'd0, busy, rinc}, 2);
      end
      if (ab) continue;
      check("data", 32'(d), 32'(e.data));
      if (e.par_en) begin
        @(negedge clk);
        if (!rst_n) continue;
        check("parity", {30'd0, tx_out, busy}, {30'd0, e.par_bit, 1'b1});
      end
      @(negedge clk);
      if (!rst_n) continue;
      check("stop", {29'd0, tx_out, busy, rinc}, 3'b110);
    end
  end

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (tx_out == 1'b0) ok = 1'b1;
    end
    check("start_seen", 32'(ok), 1);
  endtask

  // Called on a start-bit negedge; counts contiguous busy cycles.
  task automatic measure(output int len);
    len = 0;
    while (busy == 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [9:0] line_v, rinc_v, busy_v;
    int len, r0, s0, gap, bad;

    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, tx_out, busy, rinc}, 3'b100);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5, no parity: exact line, rinc and busy waveforms
    par_en = 1'b0;
    push(8'hA5, 1'b0, 1'b0);
    wait_start();
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      line_v[i] = tx_out;
      rinc_v[i] = rinc;
      busy_v[i] = busy;
    end
    check("a5_line", 32'(line_v), 32'(10'b1101001010));
    check("a5_rinc", 32'(rinc_v), 32'(10'b0000000001));
    check("a5_busy", 32'(busy_v), 32'(10'b1111111111));
    @(negedge clk);
    check("a5_after_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // 0xA5 with even then odd parity
    par_en  = 1'b1;
    par_typ = 1'b0;
    push(8'hA5, 1'b1, 1'b0);
    wait_start();
    measure(len);
    check("even_len", len, 11);
    par_typ = 1'b1;
    push(8'hA5, 1'b1, 1'b1);
    wait_start();
    measure(len);
    check("odd_len", len, 11);
    repeat (2) @(negedge clk);

    // back-to-back 0x01, 0x80
    par_en = 1'b0;
    r0 = rinc_cnt;
    s0 = starts.size();
    push(8'h01, 1'b0, 1'b0);
    push(8'h80, 1'b0, 1'b0);
    wait_start();
    measure(len);
    check("b2b_len", len, 20);
    check("b2b_rinc", rinc_cnt - r0, 2);
    gap = (starts.size() >= s0 + 2) ? starts[s0+1] - starts[s0] : -1;
    check("b2b_gap", gap, 10);

    // empty FIFO for 50 cycles
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({tx_out, busy, rinc} !== 3'b100) bad++;
    end
    check("idle50_bad", bad, 0);

    // reset asserted during data bit 3
    push(8'h3C, 1'b0, 1'b0);
    wait_start();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort", {29'd0, tx_out, busy, rinc}, 3'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({tx_out, busy, rinc} !== 3'b100) bad++;
    end
    check("post_rst_idle_bad", bad, 0);
    check("rst_fifo_empty", 32'(fifo.size()), 0);

    // par_typ toggled mid-frame: current frame keeps even, next gets odd
    par_en  = 1'b1;
    par_typ = 1'b0;
    push(8'h0F, 1'b1, 1'b0);
    push(8'h0F, 1'b1, 1'b1);
    wait_start();
    repeat (3) @(negedge clk);
    par_typ = 1'b1;
    measure(len);
    check("toggle_len", len, 19);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the FIFO read data and of the serialised payload.
REQ-002 clk  input  1  transmit bit clock; one clk cycle = one UART bit time.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rempty  input  1  upstream async FIFO read-side empty flag, synchronous to clk.
REQ-005 rdata  input  DATA_WIDTH  upstream FIFO head word, valid whenever rempty is low.
REQ-006 par_en  input  1  1 = append parity bit.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 rinc  output  1  registered one-cycle pop pulse to the FIFO read side.
REQ-009 tx_out  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  registered, high while a frame is on the line.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; the state is the bit currently driven on tx_out.
REQ-012 IDLE: tx_out=1 and busy=0; at a clock edge with rempty=0, latch rdata, par_en and par_typ, set rinc=1 for exactly the next cycle, and go to START.
REQ-013 START: tx_out=0; at the next edge, clear the bit counter and go to DATA.
REQ-014 DATA: tx_out = latched data bit, LSB first; after DATA_WIDTH cycles, go to PARITY if latched par_en=1, else go to STOP.
REQ-015 PARITY: tx_out = XOR of the latched data when par_typ=0, and its inverse when par_typ=1; one cycle, then go to STOP.
REQ-016 STOP: tx_out=1 for one cycle; at its ending edge, if rempty=0, apply REQ-012 and go directly to START (no idle gap); otherwise go to IDLE.
REQ-017 Latency: rempty sampled low at edge E0 -> tx_out=0 and rinc=1 in the cycle after E0.
REQ-018 Frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-019 rinc SHALL pulse exactly once per frame and never while rempty=1 at the sampling edge.
REQ-020 Changes to par_en or par_typ mid-frame SHALL NOT affect the frame in progress.
REQ-021 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-022 rdata SHALL be ignored outside the latching edges.

Reset
REQ-023 While rst_n=0: state IDLE, tx_out=1, busy=0, rinc=0, bit counter 0, data register 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately (tx_out returns high asynchronously); a word already popped is discarded and is not retransmitted.
REQ-025 After release, the first frame SHALL start only on a sampled rempty=0.

Structure
REQ-026 Shared package uart_tx_pkg SHALL hold the state enum, parity-type constants (PAR_EVEN=0, PAR_ODD=1) and the default DATA_WIDTH.
REQ-027 One sub-module, uart_tx_serializer (load, shift, bit counter, done flag), SHALL be used; the FSM, parity and output registers stay in uart_tx.

Verification
REQ-028 0xA5, par_en=0, one word -> tx_out 0,1,0,1,0,0,1,0,1,1 over 10 cycles; rinc high only in cycle 1; busy high for 10 cycles.
REQ-029 0xA5, par_en=1, par_typ=0 then par_typ=1 -> parity bit 0 then 1; 11-cycle frames.
REQ-030 Back-to-back 0x01, 0x80, par_en=0 -> 20 contiguous frame cycles with no idle high between frames; rinc pulses exactly twice, 10 cycles apart.
REQ-031 rempty held high for 50 cycles -> tx_out=1, busy=0, rinc=0 throughout.
REQ-032 rst_n asserted in DATA bit 3 -> tx_out=1 and busy=0 immediately; after release with rempty=1, the line stays idle.
REQ-033 par_typ toggled mid-frame with 0x0F and even parity -> parity bit 0, and the next frame uses the new value.
